// File: rtl/ppu_vram_arb_if.sv
// Bus between the PPU VRAM arbiter and its three requesters plus the VRAM port.
interface ppu_vram_arb_if #(
    parameter int unsigned ADDR_W = 14
);
    logic              rendering_in;
    logic              bg_req_in;
    logic [ADDR_W-1:0] bg_addr_in;
    logic              bg_ack_out;
    logic              bg_rvalid_out;
    logic              spr_req_in;
    logic [ADDR_W-1:0] spr_addr_in;
    logic              spr_ack_out;
    logic              spr_rvalid_out;
    logic              cpu_req_in;
    logic              cpu_we_in;
    logic [ADDR_W-1:0] cpu_addr_in;
    logic [7:0]        cpu_wdata_in;
    logic              cpu_ack_out;
    logic              cpu_rvalid_out;
    logic [7:0]        rd_data_out;
    logic              vram_en_out;
    logic              vram_we_out;
    logic [ADDR_W-1:0] vram_addr_out;
    logic [7:0]        vram_wdata_out;
    logic [7:0]        vram_data_in;

    // Arbiter side.
    modport slave (
        input  rendering_in, bg_req_in, bg_addr_in, spr_req_in, spr_addr_in,
               cpu_req_in, cpu_we_in, cpu_addr_in, cpu_wdata_in, vram_data_in,
        output bg_ack_out, bg_rvalid_out, spr_ack_out, spr_rvalid_out,
               cpu_ack_out, cpu_rvalid_out, rd_data_out,
               vram_en_out, vram_we_out, vram_addr_out, vram_wdata_out
    );

    // Requester / memory side.
    modport master (
        output rendering_in, bg_req_in, bg_addr_in, spr_req_in, spr_addr_in,
               cpu_req_in, cpu_we_in, cpu_addr_in, cpu_wdata_in, vram_data_in,
        input  bg_ack_out, bg_rvalid_out, spr_ack_out, spr_rvalid_out,
               cpu_ack_out, cpu_rvalid_out, rd_data_out,
               vram_en_out, vram_we_out, vram_addr_out, vram_wdata_out
    );
endinterface

// File: rtl/ppu_vram_arb.sv
// PPU VRAM port arbiter: one access per cycle shared by the background fetcher,
// sprite fetcher and CPU port, with a tagged pipeline routing read data back.
module ppu_vram_arb #(
    parameter int unsigned ADDR_W     = 14,
    parameter int unsigned RD_LAT     = 1,
    parameter int unsigned STARVE_MAX = 7
) (
    input logic           clk_in,
    input logic           rst_n_in,
    ppu_vram_arb_if.slave bus
);
    typedef enum logic [1:0] {TagNone, TagBg, TagSpr, TagCpu} tag_e;

    localparam logic [7:0] StarveLim = 8'(STARVE_MAX);

    logic              grant_bg;
    logic              grant_spr;
    logic              grant_cpu;
    logic              starve;
    logic [ADDR_W-1:0] grant_addr;
    tag_e              tag_d;
    tag_e              tag_end;
    logic [7:0]        cpu_wait_q;
    logic [7:0]        cpu_wait_d;

    // Stage k of the tag pipe sits in bits [2k+1:2k]; stage RD_LAT is the one
    // whose data is on vram_data_in this cycle.
    logic [2*RD_LAT+1:0] tag_pipe_q;

    logic              vram_en_q;
    logic              vram_we_q;
    logic [ADDR_W-1:0] vram_addr_q;
    logic [7:0]        vram_wdata_q;
    logic [7:0]        rd_data_q;
    logic              bg_rvalid_q;
    logic              spr_rvalid_q;
    logic              cpu_rvalid_q;

    // Arbitration: starved CPU first, then the rendering-dependent fixed priority.
    always_comb begin
        grant_bg  = 1'b0;
        grant_spr = 1'b0;
        grant_cpu = 1'b0;
        starve    = bus.cpu_req_in && (cpu_wait_q == StarveLim);
        if (rst_n_in) begin
            if (starve) begin
                grant_cpu = 1'b1;
            end else if (bus.rendering_in) begin
                if (bus.bg_req_in)       grant_bg  = 1'b1;
                else if (bus.spr_req_in) grant_spr = 1'b1;
                else if (bus.cpu_req_in) grant_cpu = 1'b1;
            end else begin
                if (bus.cpu_req_in)      grant_cpu = 1'b1;
                else if (bus.bg_req_in)  grant_bg  = 1'b1;
                else if (bus.spr_req_in) grant_spr = 1'b1;
            end
        end
    end

    // Winning address, read tag and next starvation count.
    always_comb begin
        grant_addr = bus.cpu_addr_in;
        tag_d      = TagNone;
        if (grant_bg) begin
            grant_addr = bus.bg_addr_in;
            tag_d      = TagBg;
        end else if (grant_spr) begin
            grant_addr = bus.spr_addr_in;
            tag_d      = TagSpr;
        end else if (grant_cpu && !bus.cpu_we_in) begin
            tag_d = TagCpu;
        end

        cpu_wait_d = cpu_wait_q;
        if (!bus.cpu_req_in || grant_cpu) begin
            cpu_wait_d = 8'd0;
        end else if (cpu_wait_q < StarveLim) begin
            cpu_wait_d = cpu_wait_q + 8'd1;
        end
    end

    assign tag_end = tag_e'(tag_pipe_q[2*RD_LAT+1 -: 2]);

    // Starvation counter and read tag pipeline.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            cpu_wait_q <= 8'd0;
            tag_pipe_q <= '0;
        end else begin
            cpu_wait_q <= cpu_wait_d;
            if (RD_LAT == 0) begin
                tag_pipe_q <= tag_d;
            end else begin
                tag_pipe_q <= {tag_pipe_q[2*RD_LAT-1:0], tag_d};
            end
        end
    end

    // Register the granted access onto the VRAM port; address/data hold when idle.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            vram_en_q    <= 1'b0;
            vram_we_q    <= 1'b0;
            vram_addr_q  <= '0;
            vram_wdata_q <= 8'd0;
        end else begin
            vram_en_q <= grant_bg || grant_spr || grant_cpu;
            vram_we_q <= grant_cpu && bus.cpu_we_in;
            if (grant_bg || grant_spr || grant_cpu) begin
                vram_addr_q <= grant_addr;
            end
            if (grant_cpu && bus.cpu_we_in) begin
                vram_wdata_q <= bus.cpu_wdata_in;
            end
        end
    end

    // Capture read data and strobe the owner's rvalid when a tag retires.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            rd_data_q    <= 8'd0;
            bg_rvalid_q  <= 1'b0;
            spr_rvalid_q <= 1'b0;
            cpu_rvalid_q <= 1'b0;
        end else begin
            bg_rvalid_q  <= (tag_end == TagBg);
            spr_rvalid_q <= (tag_end == TagSpr);
            cpu_rvalid_q <= (tag_end == TagCpu);
            if (tag_end != TagNone) begin
                rd_data_q <= bus.vram_data_in;
            end
        end
    end

    assign bus.bg_ack_out     = grant_bg;
    assign bus.spr_ack_out    = grant_spr;
    assign bus.cpu_ack_out    = grant_cpu;
    assign bus.bg_rvalid_out  = bg_rvalid_q;
    assign bus.spr_rvalid_out = spr_rvalid_q;
    assign bus.cpu_rvalid_out = cpu_rvalid_q;
    assign bus.rd_data_out    = rd_data_q;
    assign bus.vram_en_out    = vram_en_q;
    assign bus.vram_we_out    = vram_we_q;
    assign bus.vram_addr_out  = vram_addr_q;
    assign bus.vram_wdata_out = vram_wdata_q;
endmodule

// File: doc/ppu_vram_arb.md
# ppu_vram_arb

Arbiter and sequencer for the PPU's single 14-bit VRAM port. It shares the port between three requesters: the background fetcher, the sprite fetcher and the CPU data port ($2007). It issues at most one access per cycle and pipelines reads with requester tags. Each requester gets its own read-valid strobe. It sits between the PPU fetch units and the VRAM/CHR memory.

## Interface
Parameters:
- `ADDR_W`, 14, VRAM address width.
- `RD_LAT`, 1, VRAM read latency in cycles (legal 1..3).
- `STARVE_MAX`, 7, maximum consecutive lost arbitrations for the CPU before it is forced to win (1..255).

Ports:
- `clk_in`  in  1  system clock; all logic on the rising edge.
- `rst_n_in`  in  1  reset: asynchronous, active-low.
- `rendering_in`  in  1  1 = rendering active, so fetchers take priority.
- `bg_req_in`  in  1  background read request (level).
- `bg_addr_in`  in  ADDR_W  background read address.
- `bg_ack_out`  out  1  background grant, combinational, one cycle.
- `bg_rvalid_out`  out  1  background read data valid on `rd_data_out`.
- `spr_req_in`, `spr_addr_in`, `spr_ack_out`, `spr_rvalid_out`  same as bg, for sprites.
- `cpu_req_in`  in  1  CPU request (level).
- `cpu_we_in`  in  1  1 = write, 0 = read.
- `cpu_addr_in`  in  ADDR_W  CPU address.
- `cpu_wdata_in`  in  8  CPU write data.
- `cpu_ack_out`  out  1  CPU grant, combinational, one cycle.
- `cpu_rvalid_out`  out  1  CPU read data valid.
- `rd_data_out`  out  8  registered read data, shared by all requesters.
- `vram_en_out`  out  1  registered VRAM access strobe.
- `vram_we_out`  out  1  registered VRAM write enable.
- `vram_addr_out`  out  ADDR_W  registered VRAM address.
- `vram_wdata_out`  out  8  registered VRAM write data.
- `vram_data_in`  in  8  VRAM read data.

## Operation
- **Request protocol**
  - A requester holds `req`, `addr`, `we` and `wdata` stable until it sees `ack` high.
  - It may drop the request, or present the next one, on the edge that ends the ack cycle.
  - At most one ack per cycle.
- **Priority when `rendering_in`=1:** bg > spr > cpu.
- **Priority when `rendering_in`=0:** cpu > bg > spr.
- **Starvation counter `cpu_wait`** (8-bit, saturating at `STARVE_MAX`)
  - Increments each cycle that `cpu_req_in`=1 and `cpu_ack_out`=0.
  - Clears on `cpu_ack_out`=1 or on `cpu_req_in`=0.
  - While `cpu_wait`==`STARVE_MAX` and `cpu_req_in`=1, the CPU wins regardless of priority.
- **Granted access**
  - On the edge ending the ack cycle, the block registers `vram_en_out`=1 and the address.
  - For a CPU write it also registers `vram_we_out`=1 and `vram_wdata_out`.
  - With no grant: `vram_en_out`=0 and `vram_we_out`=0; `vram_addr_out` and `vram_wdata_out` hold their previous values.
- **Read tag pipeline**
  - Depth `RD_LAT`+1; the tag is {none, bg, spr, cpu}.
  - A write enters tag "none", so writes never produce an rvalid.
  - When a tag reaches the end, `rd_data_out` is loaded from `vram_data_in` and the matching rvalid pulses for one cycle.
  - `rd_data_out` holds its value otherwise.
- **Pipelining:** reads are fully pipelined; back-to-back grants to any mix of requesters are legal every cycle.
- **Address width:** addresses pass through unmodified at `ADDR_W` bits; there is no mirroring here.

## Timing
- **Ack latency:** ack is combinational in the cycle T in which `req` is high and wins.
- **VRAM access:** in cycle A = T+1.
- **VRAM data:** valid on `vram_data_in` in cycle A+`RD_LAT`.
- **Read data out:** `rd_data_out` and rvalid are high in cycle A+`RD_LAT`+1, i.e. T+`RD_LAT`+2 (T+3 at default).
- **Write:** effective in cycle A; no response beyond ack.
- **Reset values**
  - All acks, rvalids, `vram_en_out` and `vram_we_out` are 0.
  - `vram_addr_out`, `vram_wdata_out` and `rd_data_out` are 0.
  - `cpu_wait` is 0; the tag pipeline is all "none".
- **Reset mid-operation:** in-flight reads are discarded and no rvalid is ever produced for them. Acks are forced to 0 while `rst_n_in`=0.
- **`rendering_in` change:** takes effect in the same cycle's arbitration.
- **Simultaneous starvation and bg/spr requests:** the CPU wins, bg/spr get ack=0, and they must keep requesting.
- **Request dropped without ack:** legal. No access occurs and `cpu_wait` clears.

## Test plan
- **Reset:** assert `rst_n_in`=0 mid-stream with a read in flight -> all outputs 0 immediately; no rvalid after release.
- **Single background read:** bg read at 0x2041 in cycle T with memory[0x2041]=0x5A, `RD_LAT`=1 -> `bg_ack_out` in T; `vram_en_out`=1 and `vram_addr_out`=0x2041 in T+1; `bg_rvalid_out`=1 and `rd_data_out`=0x5A in T+3.
- **All three requesting with `rendering_in`=1:** bg, spr and cpu reads held continuously; bg drops after its ack, spr drops after its ack -> acks in order bg (T), spr (T+1), cpu (T+2). Rvalids in T+3, T+4, T+5 with the correct per-address data.
- **CPU starvation:** bg requesting every cycle, `rendering_in`=1, CPU write 0x3F00 <= 0x0F raised at T0 -> `cpu_ack_out` in T7 (8th cycle); `bg_ack_out`=0 in T7; memory[0x3F00]=0x0F; no `cpu_rvalid_out`.
- **Non-rendering priority:** `rendering_in`=0 with cpu and bg requesting simultaneously -> CPU acked first; bg acked next cycle.
- **Latency sweep:** `RD_LAT`=3 with four back-to-back alternating bg/cpu reads -> rvalids in T+5..T+8, correctly tagged, with data in order.
